issue_fifo: RTL and testbench

Parametrised multi-push / multi-pop issue queue between decode and issue, replacing the fixed 4-in/2-out queue. Decode pushes up to PUSH_W entries per cycle; issue pops up to POP_W in-order entries per cycle. Depth, port widths and entry width are parameters. Adds group-reject push semantics, pop clamping, a sticky overflow flag and a peak-occupancy counter.

---
 rtl/issue_fifo_pkg.sv | 14 +
 rtl/issue_fifo_bank.sv | 32 +++
 rtl/issue_fifo.sv | 101 ++++++++++
 tb/tb_issue_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/issue_fifo_pkg.sv
// Shared issue-queue types and default geometry for decode, issue and the queue itself.
package issue_fifo_pkg;

    typedef struct packed {
        logic [5:0] rob_tag;
        logic [3:0] fu_sel;
        logic [5:0] dst_reg;
    } issue_queue_element_t;

    localparam int IQ_DEPTH  = 8;
    localparam int IQ_PUSH_W = 4;
    localparam int IQ_POP_W  = 2;

endpackage

// File: rtl/issue_fifo_bank.sv
// Issue-queue entry storage: multi-port write, combinational multi-port read, no reset.
module issue_fifo_bank #(
    parameter int DEPTH  = 8,
    parameter int PUSH_W = 4,
    parameter int POP_W  = 2,
    parameter int DATA_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic [PUSH_W-1:0]              we,
    input  logic [PUSH_W-1:0][AW-1:0]      widx,
    input  logic [PUSH_W-1:0][DATA_W-1:0]  wdata,
    input  logic [POP_W-1:0][AW-1:0]       ridx,
    output logic [POP_W-1:0][DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write indices within one push group are consecutive, so ports never collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_W; i++) begin
            if (we[i]) mem[widx[i]] <= wdata[i];
        end
    end

    always_comb begin
        for (int j = 0; j < POP_W; j++) begin
            rdata[j] = mem[ridx[j]];
        end
    end

endmodule

// File: rtl/issue_fifo.sv
// Multi-push / multi-pop in-order issue queue with group-reject push, pop clamping,
// sticky overflow and peak-occupancy tracking.
module issue_fifo
    import issue_fifo_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PUSH_W = IQ_PUSH_W,
    parameter int POP_W  = IQ_POP_W,
    parameter int DATA_W = $bits(issue_queue_element_t),
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int NW    = $clog2(PUSH_W + 1),
    localparam int PW    = $clog2(POP_W + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flash,
    input  logic [PUSH_W-1:0][DATA_W-1:0]  in_data,
    input  logic [NW-1:0]                  in_number,
    input  logic [PW-1:0]                  out_number,
    output logic [POP_W-1:0][DATA_W-1:0]   out_data,
    output logic [POP_W-1:0]               out_valid,
    output logic [PW-1:0]                  iq_size,
    output logic [CW-1:0]                  iq_size_left,
    output logic [CW-1:0]                  iq_count,
    output logic                           overflow,
    output logic [CW-1:0]                  peak
);

    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, peak_q;
    logic          overflow_q;

    logic [CW-1:0] push_n, pop_n, count_next;
    logic          push_fits, push_acc, push_rej;

    logic [PUSH_W-1:0]             we;
    logic [PUSH_W-1:0][AW-1:0]     widx;
    logic [POP_W-1:0][AW-1:0]      ridx;

    // Space check uses the registered free count only; a same-cycle pop gives no credit.
    assign iq_size_left = CW'(DEPTH) - count_q;
    assign push_fits    = CW'(in_number) <= iq_size_left;
    assign push_acc     = !flash && push_fits;
    assign push_rej     = !flash && !push_fits;
    assign push_n       = push_acc ? CW'(in_number) : '0;
    assign pop_n        = (CW'(out_number) < count_q) ? CW'(out_number) : count_q;
    assign count_next   = count_q + push_n - pop_n;

    always_comb begin
        for (int i = 0; i < PUSH_W; i++) begin
            we[i]   = push_acc && (NW'(i) < in_number);
            widx[i] = tail_q + AW'(i);
        end
        for (int j = 0; j < POP_W; j++) begin
            ridx[j]      = head_q + AW'(j);
            out_valid[j] = CW'(j) < count_q;
        end
    end

    issue_fifo_bank #(
        .DEPTH  (DEPTH),
        .PUSH_W (PUSH_W),
        .POP_W  (POP_W),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk    (clk),
        .we     (we),
        .widx   (widx),
        .wdata  (in_data),
        .ridx   (ridx),
        .rdata  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            peak_q     <= '0;
            overflow_q <= 1'b0;
        end else if (flash) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            peak_q  <= '0;
        end else begin
            head_q  <= head_q + AW'(pop_n);
            tail_q  <= tail_q + AW'(push_n);
            count_q <= count_next;
            if (push_rej) overflow_q <= 1'b1;
            if (count_next > peak_q) peak_q <= count_next;
        end
    end

    assign iq_size  = (count_q < CW'(POP_W)) ? count_q[PW-1:0] : PW'(POP_W);
    assign iq_count = count_q;
    assign overflow = overflow_q;
    assign peak     = peak_q;

endmodule

// File: tb/tb_issue_fifo.sv
// Self-checking bench: directed table on the default 8/4/2 queue, reset corner,
// and a randomised 16/3/3 queue against a queue scoreboard.
module tb_issue_fifo;
    import issue_fifo_pkg::*;

    localparam int DW = $bits(issue_queue_element_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default configuration: DEPTH 8, PUSH_W 4, POP_W 2
    logic              flash1 = 1'b0;
    logic [3:0][DW-1:0] in_data1 = '0;
    logic [2:0]        in_num1 = '0;
    logic [1:0]        out_num1 = '0;
    logic [1:0][DW-1:0] out_data1;
    logic [1:0]        out_valid1;
    logic [1:0]        iq_size1;
    logic [3:0]        left1, count1, peak1;
    logic              ovf1;

    issue_fifo dut1 (
        .clk(clk), .rst_n(rst_n), .flash(flash1), .in_data(in_data1),
        .in_number(in_num1), .out_number(out_num1), .out_data(out_data1),
        .out_valid(out_valid1), .iq_size(iq_size1), .iq_size_left(left1),
        .iq_count(count1), .overflow(ovf1), .peak(peak1)
    );

    // random configuration: DEPTH 16, PUSH_W 3, POP_W 3
    logic              flash2 = 1'b0;
    logic [2:0][DW-1:0] in_data2 = '0;
    logic [1:0]        in_num2 = '0;
    logic [1:0]        out_num2 = '0;
    logic [2:0][DW-1:0] out_data2;
    logic [2:0]        out_valid2;
    logic [1:0]        iq_size2;
    logic [4:0]        left2, count2, peak2;
    logic              ovf2;

    issue_fifo #(.DEPTH(16), .PUSH_W(3), .POP_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .flash(flash2), .in_data(in_data2),
        .in_number(in_num2), .out_number(out_num2), .out_data(out_data2),
        .out_valid(out_valid2), .iq_size(iq_size2), .iq_size_left(left2),
        .iq_count(count2), .overflow(ovf2), .peak(peak2)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // scoreboard model for dut1
    logic [DW-1:0] q1[$];
    bit            ov1 = 0;
    int            pk1 = 0;

    task automatic step1(input int push, input int pop, input bit fl, input int tag);
        int p;
        bit ok;
        for (int i = 0; i < 4; i++) in_data1[i] = DW'(tag * 4 + i);
        in_num1  = 3'(push);
        out_num1 = 2'(pop);
        flash1   = fl;
        @(posedge clk);
        if (fl) begin
            q1.delete();
            pk1 = 0;
        end else begin
            p  = (pop < q1.size()) ? pop : q1.size();
            ok = push <= 8 - q1.size();
            if (!ok) ov1 = 1;
            repeat (p) void'(q1.pop_front());
            if (ok) for (int i = 0; i < push; i++) q1.push_back(DW'(tag * 4 + i));
            if (q1.size() > pk1) pk1 = q1.size();
        end
        #1;
        chk("left1", left1, 8 - q1.size());
        chk("iq_size1", iq_size1, (q1.size() < 2) ? q1.size() : 2);
        for (int i = 0; i < 2; i++) begin
            if (i < q1.size()) chk($sformatf("data1[%0d]", i), out_data1[i], q1[i]);
        end
    endtask

    typedef struct {
        int         push;
        int         pop;
        bit         fl;
        int         e_count;
        logic [1:0] e_valid;
        bit         e_ovf;
        int         e_peak;
    } vec_t;

    vec_t tbl[17];

    // scoreboard model for dut2
    logic [DW-1:0] q2[$];
    bit            ov2 = 0;
    int            pk2 = 0;

    initial begin
        tbl[0]  = '{3, 0, 0, 3, 2'b11, 0, 3};
        tbl[1]  = '{3, 0, 0, 6, 2'b11, 0, 6};
        tbl[2]  = '{0, 2, 0, 4, 2'b11, 0, 6};
        tbl[3]  = '{0, 2, 0, 2, 2'b11, 0, 6};
        tbl[4]  = '{0, 2, 0, 0, 2'b00, 0, 6};
        tbl[5]  = '{4, 2, 0, 4, 2'b11, 0, 6};   // pop clamps on empty, push wraps 6,7,0,1
        tbl[6]  = '{4, 2, 0, 6, 2'b11, 0, 6};
        tbl[7]  = '{1, 0, 0, 7, 2'b11, 0, 7};
        tbl[8]  = '{2, 0, 0, 7, 2'b11, 1, 7};   // group reject
        tbl[9]  = '{1, 0, 0, 8, 2'b11, 1, 8};
        tbl[10] = '{1, 1, 0, 7, 2'b11, 1, 8};   // full: push rejected, pop still applies
        tbl[11] = '{0, 2, 0, 5, 2'b11, 1, 8};
        tbl[12] = '{3, 2, 1, 0, 2'b00, 1, 0};   // flash wins over push and pop
        tbl[13] = '{1, 2, 0, 1, 2'b01, 1, 1};
        tbl[14] = '{0, 2, 0, 0, 2'b00, 1, 1};
        tbl[15] = '{2, 0, 0, 2, 2'b11, 1, 2};
        tbl[16] = '{0, 1, 0, 1, 2'b01, 1, 2};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_count", count1, 0);
        chk("rst_valid", out_valid1, 0);
        chk("rst_size", iq_size1, 0);
        chk("rst_left", left1, 8);
        chk("rst_ovf", ovf1, 0);
        chk("rst_peak", peak1, 0);

        for (int k = 0; k < 17; k++) begin
            step1(tbl[k].push, tbl[k].pop, tbl[k].fl, k + 1);
            chk($sformatf("count[%0d]", k), count1, tbl[k].e_count);
            chk($sformatf("valid[%0d]", k), out_valid1, tbl[k].e_valid);
            chk($sformatf("ovf[%0d]", k), ovf1, tbl[k].e_ovf);
            chk($sformatf("peak[%0d]", k), peak1, tbl[k].e_peak);
        end

        // asynchronous reset in the middle of a push
        step1(3, 0, 0, 40);
        in_num1 = 3'd3;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count1, 0);
        chk("arst_valid", out_valid1, 0);
        chk("arst_ovf", ovf1, 0);
        chk("arst_left", left1, 8);
        q1.delete();
        ov1 = 0;
        pk1 = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_num1 = '0;
        @(posedge clk);
        #1;
        chk("post_rst_count", count1, 0);
        chk("post_rst_valid", out_valid1, 0);
        chk("post_rst_peak", peak1, 0);

        // randomised traffic on the 16/3/3 instance
        for (int c = 0; c < 4000; c++) begin
            int n, p, pe;
            bit fl, ok;
            n  = $urandom_range(0, 3);
            p  = $urandom_range(0, 3);
            fl = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 3; i++) in_data2[i] = DW'($urandom);
            in_num2  = 2'(n);
            out_num2 = 2'(p);
            flash2   = fl;
            pe = (p < q2.size()) ? p : q2.size();
            if (!fl) begin
                for (int i = 0; i < pe; i++) chk("pop_data2", out_data2[i], q2[i]);
            end
            @(posedge clk);
            if (fl) begin
                q2.delete();
                pk2 = 0;
            end else begin
                ok = n <= 16 - q2.size();
                if (!ok) ov2 = 1;
                repeat (pe) void'(q2.pop_front());
                if (ok) for (int i = 0; i < n; i++) q2.push_back(in_data2[i]);
                if (q2.size() > pk2) pk2 = q2.size();
            end
            #1;
            chk("count2", count2, q2.size());
            chk("peak2", peak2, pk2);
            chk("ovf2", ovf2, ov2);
            for (int i = 0; i < 3; i++) chk("valid2", out_valid2[i], i < q2.size());
        end
        flash2   = 1'b0;
        in_num2  = '0;
        out_num2 = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
